minicpu_sequencer: RTL

- Program sequencer that drives the MiniCPU control interface from a small writable instruction store. It issues opcode, wr_addr, rd_addr1, rd_addr2 and wr_data to the CPU.
- It is the initiator side of the CPU's control port and replaces hand-driven stimulus with a fetch/issue state machine.
- Sits between a host or loader (program load, start) and the MiniCPU datapath.

---
 rtl/minicpu_pkg.sv | 27 ++
 rtl/minicpu_sequencer_if.sv | 22 ++
 rtl/minicpu_prog_mem.sv | 35 +++
 rtl/minicpu_sequencer.sv | 117 +++++++++++
 4 files changed

// File: rtl/minicpu_pkg.sv
// Shared definitions for the MiniCPU program sequencer: opcodes, instruction
// field positions and the sequencer state encoding.
package minicpu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;

   localparam int unsigned OPCODE_MSB   = 15;
   localparam int unsigned OPCODE_LSB   = 13;
   localparam int unsigned WR_ADDR_MSB  = 12;
   localparam int unsigned WR_ADDR_LSB  = 11;
   localparam int unsigned RD_ADDR1_MSB = 10;
   localparam int unsigned RD_ADDR1_LSB = 9;
   localparam int unsigned RD_ADDR2_MSB = 8;
   localparam int unsigned RD_ADDR2_LSB = 7;
   localparam int unsigned WR_DATA_MSB  = 6;
   localparam int unsigned WR_DATA_LSB  = 3;
   localparam int unsigned HALT_BIT     = 2;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StIssue,
      StDone
   } seq_state_e;

endpackage

// File: rtl/minicpu_sequencer_if.sv
// Control port between the sequencer (master) and the MiniCPU datapath (slave).
interface minicpu_sequencer_if;

   logic       instr_valid;
   logic [2:0] opcode;
   logic [1:0] wr_addr;
   logic [1:0] rd_addr1;
   logic [1:0] rd_addr2;
   logic [3:0] wr_data;
   logic [3:0] alu_result;

   modport master (
      output instr_valid, opcode, wr_addr, rd_addr1, rd_addr2, wr_data,
      input  alu_result
   );

   modport slave (
      input  instr_valid, opcode, wr_addr, rd_addr1, rd_addr2, wr_data,
      output alu_result
   );

endinterface

// File: rtl/minicpu_prog_mem.sv
// DEPTH x 16 instruction store: one write port, synchronous read with read
// enable; the read register is cleared on reset, the array is not.
module minicpu_prog_mem #(
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rdata only moves on a read, so it doubles as the held instruction word
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/minicpu_sequencer.sv
// Fetch/issue sequencer driving the MiniCPU control port from a writable store.
// Optional signature trace over alu_result is enabled by MINICPU_SEQ_TRACE_EN.
module minicpu_sequencer
   import minicpu_pkg::*;
#(
   parameter int unsigned AW          = 4,
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                prog_we,
   input  logic [AW-1:0]       prog_addr,
   input  logic [15:0]         prog_data,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       pc,
   minicpu_sequencer_if.master cpu
`ifdef MINICPU_SEQ_TRACE_EN
   ,
   output logic [3:0]          sig,
   output logic [AW:0]         sig_count
`endif
);

   seq_state_e  state;
   logic [3:0]  hold_cnt;
   logic [15:0] instr;
   logic        instr_valid;
   logic        last_hold;
   logic        stop;

   assign last_hold = (state == StIssue) && (hold_cnt == 4'(HOLD_CYCLES - 1));
   assign stop      = instr[HALT_BIT] || (pc == {AW{1'b1}});

   minicpu_prog_mem #(
      .AW(AW)
   ) u_prog_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (prog_we && !busy),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (state == StFetch),
      .raddr (pc),
      .rdata (instr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         pc          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         instr_valid <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state <= StFetch;
                  pc    <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            StFetch: begin
               state       <= StIssue;
               instr_valid <= 1'b1;
               hold_cnt    <= '0;
            end
            StIssue: begin
               if (last_hold) begin
                  instr_valid <= 1'b0;
                  if (stop) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= StFetch;
                     pc    <= pc + AW'(1);
                  end
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign cpu.instr_valid = instr_valid;
   assign cpu.opcode      = instr[OPCODE_MSB:OPCODE_LSB];
   assign cpu.wr_addr     = instr[WR_ADDR_MSB:WR_ADDR_LSB];
   assign cpu.rd_addr1    = instr[RD_ADDR1_MSB:RD_ADDR1_LSB];
   assign cpu.rd_addr2    = instr[RD_ADDR2_MSB:RD_ADDR2_LSB];
   assign cpu.wr_data     = instr[WR_DATA_MSB:WR_DATA_LSB];

   logic unused_rsvd;
   assign unused_rsvd = ^instr[1:0];

`ifdef MINICPU_SEQ_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst || (start && (state == StIdle || state == StDone))) begin
         sig       <= '0;
         sig_count <= '0;
      end else if (last_hold) begin
         sig       <= {sig[2:0], sig[3]} ^ cpu.alu_result;
         sig_count <= sig_count + (AW + 1)'(1);
      end
   end
`else
   logic unused_alu;
   assign unused_alu = ^cpu.alu_result;
`endif

endmodule
